// File: rtl/fetch_unit.sv
// MSP430 instruction fetch stage: drives the ROM address, assembles opcode plus
// extension words, and hands the bundle to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [15:0] ROM_BASE  = 16'hC000,
    parameter logic [15:0] RESET_VEC = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_word,
    output logic [15:0] instr_ext1,
    output logic [15:0] instr_ext2,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    input  logic        pc_load,
    input  logic [15:0] pc_new
);

    localparam int unsigned W = 16;
    localparam int unsigned LW = 2;

    typedef enum logic [2:0] {VEC, OP, EXT1, EXT2, HOLD} state_t;

    state_t          state, state_d;
    logic [W-1:0]    pc, pc_d;
    logic            valid_d;
    logic [W-1:0]    word_d, ext1_d, ext2_d, ipc_d;
    logic [LW-1:0]   len_d;

    // Length decode of the word currently returned by the ROM
    logic            fmt1, fmt2, srcx, dstx;
    logic [1:0]      as_f;
    logic [3:0]      rs_f;
    logic [LW-1:0]   dec_len;

    always_comb begin
        fmt1    = (rom_out[15:12] >= 4'd4);
        fmt2    = (rom_out[15:10] == 6'b000100);
        as_f    = rom_out[5:4];
        rs_f    = fmt1 ? rom_out[11:8] : rom_out[3:0];
        srcx    = (fmt1 || fmt2) &&
                  (((as_f == 2'b01) && (rs_f != 4'd3)) ||
                   ((as_f == 2'b11) && (rs_f == 4'd0)));
        dstx    = fmt1 && rom_out[7];
        dec_len = LW'(1) + LW'(srcx) + LW'(dstx);
    end

    assign rom_addr = (state == VEC) ? W'(RESET_VEC - ROM_BASE) : W'(pc - ROM_BASE);

    // Next-state and datapath updates; a redirect overrides everything except VEC
    always_comb begin
        state_d = state;
        pc_d    = pc;
        valid_d = instr_valid;
        word_d  = instr_word;
        ext1_d  = instr_ext1;
        ext2_d  = instr_ext2;
        ipc_d   = instr_pc;
        len_d   = instr_len;
        case (state)
            VEC: begin
                pc_d    = rom_out & 16'hFFFE;
                state_d = OP;
            end
            OP: begin
                word_d = rom_out;
                ipc_d  = pc;
                pc_d   = W'(pc + 16'd2);
                len_d  = dec_len;
                if (dec_len == LW'(1)) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end else begin
                    state_d = EXT1;
                end
            end
            EXT1: begin
                ext1_d = rom_out;
                pc_d   = W'(pc + 16'd2);
                if (instr_len == LW'(2)) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end else begin
                    state_d = EXT2;
                end
            end
            EXT2: begin
                ext2_d  = rom_out;
                pc_d    = W'(pc + 16'd2);
                state_d = HOLD;
                valid_d = 1'b1;
            end
            HOLD: begin
                if (instr_valid && instr_ready) begin
                    state_d = OP;
                    valid_d = 1'b0;
                end
            end
            default: state_d = VEC;
        endcase
        if (pc_load && (state != VEC)) begin
            pc_d    = pc_new & 16'hFFFE;
            state_d = OP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= VEC;
            pc          <= '0;
            instr_valid <= 1'b0;
            instr_word  <= '0;
            instr_ext1  <= '0;
            instr_ext2  <= '0;
            instr_pc    <= '0;
            instr_len   <= LW'(1);
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instr_valid <= valid_d;
            instr_word  <= word_d;
            instr_ext1  <= ext1_d;
            instr_ext2  <= ext2_d;
            instr_pc    <= ipc_d;
            instr_len   <= len_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a word-array ROM model feeds the DUT and each
// step checks the registered bundle against hand-computed values.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] rom_addr;
    logic [15:0] rom_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word;
    logic [15:0] instr_ext1;
    logic [15:0] instr_ext2;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic        pc_load;
    logic [15:0] pc_new;

    logic [15:0] rom [0:32767];
    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_out(rom_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_word(instr_word), .instr_ext1(instr_ext1), .instr_ext2(instr_ext2),
        .instr_len(instr_len), .instr_pc(instr_pc),
        .pc_load(pc_load), .pc_new(pc_new)
    );

    assign rom_out = rom[15'(rom_addr >> 1)];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
        // word index = (addr - C000) / 2
        rom[15'h1FFF] = 16'hC001;          // reset vector at FFFE
        rom[15'h0000] = 16'h4303;          // C000 nop
        rom[15'h0001] = 16'h40B2;          // C002 mov #imm,&abs
        rom[15'h0002] = 16'h1234;
        rom[15'h0003] = 16'h0200;
        rom[15'h0004] = 16'h4392;          // C008 constant-gen src, abs dst
        rom[15'h0005] = 16'hABCD;
        rom[15'h0006] = 16'h2C00;          // C00C jump
        rom[15'h0007] = 16'h4303;          // C00E
        rom[15'h0008] = 16'h40B2;          // C010 3-word, redirected in EXT1
        rom[15'h0009] = 16'h1111;
        rom[15'h000A] = 16'h2222;
        rom[15'h0080] = 16'h4303;          // C100
        rom[15'h0100] = 16'h40B2;          // C200 3-word, reset in EXT2
        rom[15'h0101] = 16'h5555;
        rom[15'h0102] = 16'h6666;

        rst = 1'b1; instr_ready = 1'b0; pc_load = 1'b0; pc_new = 16'h0000;
        tick(); tick();
        chk("rst_valid", 16'(instr_valid), 16'h0000);
        chk("rst_len", 16'(instr_len), 16'h0001);
        chk("rst_word", instr_word, 16'h0000);
        chk("rst_pc", instr_pc, 16'h0000);
        chk("rst_addr_vec", rom_addr, 16'h3FFE);

        // Reset vector fetch, then first opcode
        rst = 1'b0;
        tick();
        chk("vec_pc_bit0", rom_addr, 16'h0000);
        chk("vec_valid", 16'(instr_valid), 16'h0000);
        tick();
        chk("t1_valid", 16'(instr_valid), 16'h0001);
        chk("t1_word", instr_word, 16'h4303);
        chk("t1_len", 16'(instr_len), 16'h0001);
        chk("t1_pc", instr_pc, 16'hC000);

        // 3-word instruction
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        chk("acc1_valid", 16'(instr_valid), 16'h0000);
        chk("acc1_addr", rom_addr, 16'h0002);
        tick();
        chk("t2_op_valid", 16'(instr_valid), 16'h0000);
        tick();
        chk("t2_ext1_valid", 16'(instr_valid), 16'h0000);
        tick();
        chk("t2_valid", 16'(instr_valid), 16'h0001);
        chk("t2_len", 16'(instr_len), 16'h0003);
        chk("t2_ext1", instr_ext1, 16'h1234);
        chk("t2_ext2", instr_ext2, 16'h0200);
        chk("t2_pc", instr_pc, 16'hC002);

        // Constant generator source: only the destination extension
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        chk("acc2_addr", rom_addr, 16'h0008);
        tick(); tick();
        chk("t3_valid", 16'(instr_valid), 16'h0001);
        chk("t3_len", 16'(instr_len), 16'h0002);
        chk("t3_ext1", instr_ext1, 16'hABCD);
        chk("t3_pc", instr_pc, 16'hC008);

        // Jump is one word
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        tick();
        chk("t3j_valid", 16'(instr_valid), 16'h0001);
        chk("t3j_len", 16'(instr_len), 16'h0001);
        chk("t3j_word", instr_word, 16'h2C00);
        chk("t3j_pc", instr_pc, 16'hC00C);

        // Backpressure: bundle and address stay frozen
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 16'(instr_valid), 16'h0001);
            chk("bp_word", instr_word, 16'h2C00);
            chk("bp_pc", instr_pc, 16'hC00C);
            chk("bp_addr", rom_addr, 16'h000E);
        end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        chk("bp_acc_valid", 16'(instr_valid), 16'h0000);
        chk("bp_acc_addr", rom_addr, 16'h000E);
        tick();
        chk("bp_next_valid", 16'(instr_valid), 16'h0001);
        chk("bp_next_pc", instr_pc, 16'hC00E);

        // Redirect during EXT1 of a 3-word instruction
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        tick();
        chk("t5_in_ext1", rom_addr, 16'h0012);
        pc_load = 1'b1; pc_new = 16'hC101;
        tick();
        pc_load = 1'b0;
        chk("t5_valid0", 16'(instr_valid), 16'h0000);
        chk("t5_addr", rom_addr, 16'h0100);
        tick();
        chk("t5_valid", 16'(instr_valid), 16'h0001);
        chk("t5_pc", instr_pc, 16'hC100);
        chk("t5_len", 16'(instr_len), 16'h0001);

        // Redirect coincident with accept
        instr_ready = 1'b1; pc_load = 1'b1; pc_new = 16'hC200;
        tick();
        instr_ready = 1'b0; pc_load = 1'b0;
        chk("t6a_valid", 16'(instr_valid), 16'h0000);
        chk("t6a_addr", rom_addr, 16'h0200);

        // Reset during EXT2
        tick(); tick();
        chk("t6b_in_ext2", rom_addr, 16'h0204);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6b_valid", 16'(instr_valid), 16'h0000);
        chk("t6b_addr_vec", rom_addr, 16'h3FFE);
        chk("t6b_len", 16'(instr_len), 16'h0001);

        // Redirect ignored in VEC, then PC wrap from FFFE
        pc_load = 1'b1; pc_new = 16'hFFFE;
        tick();
        chk("t6c_vec_ignore", rom_addr, 16'h0000);
        tick();
        pc_load = 1'b0;
        chk("t6c_redir", rom_addr, 16'h3FFE);
        chk("t6c_redir_valid", 16'(instr_valid), 16'h0000);
        tick();
        chk("t6c_valid", 16'(instr_valid), 16'h0001);
        chk("t6c_pc", instr_pc, 16'hFFFE);
        chk("t6c_word", instr_word, 16'hC001);
        chk("t6c_len", 16'(instr_len), 16'h0001);
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        chk("t6c_wrap_addr", rom_addr, 16'h4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
